// File: rtl/y86_execute_ctrl.sv
// Y86 execute-stage controller. Drives an external ALU from icode/ifun, owns the {ZF,SF,OF}
// condition codes, evaluates branch/cmov conditions and holds one result for the memory stage.
package y86_execute_ctrl_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;
endpackage

module y86_execute_ctrl
  import y86_execute_ctrl_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  output logic [1:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_ans,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] valE,
  output logic             cnd,
  output logic [3:0]       icode_out,
  output logic [2:0]       stat,
  output logic [2:0]       cc,
  output logic             halted
);

  localparam logic [WIDTH-1:0] C_PLUS8  = WIDTH'(8);
  localparam logic [WIDTH-1:0] C_MINUS8 = '0 - C_PLUS8;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_valE;
  logic             r_cnd;
  logic [3:0]       r_icode_out;
  stat_e            r_stat;
  cc_t              r_cc;
  logic             r_halted;

  logic [WIDTH-1:0] w_op_a;     // Y86 aluA
  logic [WIDTH-1:0] w_op_b;     // Y86 aluB
  logic             w_is_cond;
  logic             w_ifun_bad;
  alu_op_e          w_alu_op;
  stat_e            w_stat;
  logic             w_cnd;
  logic             w_accept;
  logic             w_cc_we;

  function automatic logic cond_eval(input logic [2:0] fn, input cc_t c);
    logic lt;
    lt = c.sf ^ c.of;
    case (fn)
      3'd0:    return 1'b1;
      3'd1:    return lt | c.zf;
      3'd2:    return lt;
      3'd3:    return c.zf;
      3'd4:    return !c.zf;
      3'd5:    return !lt;
      3'd6:    return !lt && !c.zf;
      default: return 1'b0;
    endcase
  endfunction

  // NOTE: every combinational output gets a default before the case, so no path infers a latch.
  always_comb begin
    w_op_a     = '0;
    w_op_b     = '0;
    w_is_cond  = 1'b0;
    w_ifun_bad = 1'b0;
    case (icode)
      I_RRMOVQ: begin
        w_op_a     = valA;
        w_is_cond  = 1'b1;
        w_ifun_bad = (ifun > 4'd6);
      end
      I_IRMOVQ: w_op_a = valC;
      I_RMMOVQ, I_MRMOVQ: begin
        w_op_a = valC;
        w_op_b = valB;
      end
      I_OPQ: begin
        w_op_a     = valA;
        w_op_b     = valB;
        w_ifun_bad = (ifun > 4'd3);
      end
      I_JXX: begin
        w_is_cond  = 1'b1;
        w_ifun_bad = (ifun > 4'd6);
      end
      I_CALL, I_PUSHQ: begin
        w_op_a = C_MINUS8;
        w_op_b = valB;
      end
      I_RET, I_POPQ: begin
        w_op_a = C_PLUS8;
        w_op_b = valB;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (icode == I_HALT)                      w_stat = STAT_HLT;
    else if ((icode > I_POPQ) || w_ifun_bad)  w_stat = STAT_INS;
    else                                      w_stat = STAT_AOK;
  end

  // The ALU computes alu_a OP alu_b, so Y86's "aluB OP aluA" swaps the operands here.
  assign w_alu_op    = (icode == I_OPQ) ? alu_op_e'(ifun[1:0]) : ALU_ADD;
  assign alu_control = w_alu_op;
  assign alu_a       = w_op_b;
  assign alu_b       = w_op_a;

  assign w_cnd    = w_is_cond && !w_ifun_bad && cond_eval(ifun[2:0], r_cc);
  assign in_ready = !r_halted && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_cc_we  = w_accept && (icode == I_OPQ) && !w_ifun_bad;

  // NOTE: non-blocking assignments so every register samples pre-edge values; cnd above
  // therefore sees the old CC even when the same instruction rewrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_valE      <= '0;
      r_cnd       <= 1'b0;
      r_icode_out <= I_HALT;
      r_stat      <= STAT_AOK;
      r_cc        <= cc_t'{zf: 1'b1, sf: 1'b0, of: 1'b0};
      r_halted    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_valE      <= alu_ans;
        r_cnd       <= w_cnd;
        r_icode_out <= icode;
        r_stat      <= w_stat;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_cc_we) begin
        r_cc <= cc_t'{zf: (alu_ans == '0), sf: alu_ans[WIDTH-1], of: alu_overflow};
      end
      if (w_accept && (w_stat != STAT_AOK)) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign valE      = r_valE;
  assign cnd       = r_cnd;
  assign icode_out = r_icode_out;
  assign stat      = r_stat;
  assign cc        = r_cc;
  assign halted    = r_halted;

endmodule

// File: doc/y86_execute_ctrl.md
Name: y86_execute_ctrl

Overview:
- Execute-stage controller for the Y86 processor; sequences the shared 64-bit ALU (2-bit control: 00 add, 01 sub a-b, 10 and, 11 xor; plus overflow flag).
- Decodes icode/ifun into ALU operand select and ALU function, owns the condition-code register (ZF/SF/OF) and evaluates branch/cmov conditions.
- Registers the result into a one-entry output stage with valid/ready handshakes on both sides.
- Sits between decode and memory stages; the ALU is instantiated outside this block and wired through the alu_* ports.

Parameters:
- WIDTH, 64, datapath width of valA/valB/valC/valE and ALU operands.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  controller accepts the instruction this cycle
- icode  in  4  Y86 instruction code
- ifun  in  4  Y86 function code
- valA  in  WIDTH  register operand A
- valB  in  WIDTH  register operand B
- valC  in  WIDTH  constant operand
- alu_control  out  2  function driven to the ALU, combinational
- alu_a  out  WIDTH  ALU first operand, combinational
- alu_b  out  WIDTH  ALU second operand, combinational
- alu_ans  in  WIDTH  ALU result, same cycle
- alu_overflow  in  1  ALU overflow, same cycle
- out_valid  out  1  output register holds a result
- out_ready  in  1  memory stage consumes the result
- valE  out  WIDTH  registered ALU result
- cnd  out  1  registered condition outcome
- icode_out  out  4  registered icode
- stat  out  3  registered status: 1 AOK, 2 HLT, 4 INS
- cc  out  3  current {ZF,SF,OF}
- halted  out  1  controller has stopped accepting instructions

Behaviour:
- Reset (async, rst_n=0): out_valid=0, valE=0, cnd=0, icode_out=0, stat=1 (AOK), cc={ZF=1,SF=0,OF=0}, halted=0. Reset mid-transfer discards the held result.
- in_ready = !halted && (!out_valid || out_ready).
- A transfer is accepted when in_valid && in_ready. The ALU drive is combinational from the inputs; the result is registered at that edge. Latency is 1 cycle from accept to out_valid.
- out_valid clears when out_ready=1 and no new accept occurs. Accept with out_ready=1 in the same cycle replaces the held result with no bubble.
- ALU operand mapping (ALU computes alu_a OP alu_b, so Y86 valB OP valA is formed as alu_a=aluB, alu_b=aluA):
  - aluA: 2 (rrmovq/cmov) or 6 (OPq) -> valA; 3, 4, 5 -> valC; 8 (call) or A (push) -> -8; 9 (ret) or B (pop) -> +8; all others 0.
  - aluB: 2, 3 -> 0; 4, 5, 6, 8, 9, A, B -> valB; all others 0.
- alu_control: icode 6 -> ifun[1:0]; all others 00.
- OPq with ifun>3 is treated as invalid: stat=INS.
- CC update occurs only on an accepted icode 6 with a valid ifun:
  - ZF = (alu_ans==0)
  - SF = alu_ans[WIDTH-1]
  - OF = alu_overflow
  - The new CC is visible to the next accepted instruction.
- cnd is evaluated from CC before any update in the same cycle, for icode 2 and 7:
  - ifun 0: 1
  - ifun 1: (SF^OF)|ZF
  - ifun 2: SF^OF
  - ifun 3: ZF
  - ifun 4: !ZF
  - ifun 5: !(SF^OF)
  - ifun 6: !(SF^OF)&!ZF
  - ifun >6: cnd=0, stat=INS
  - All other icodes: cnd=0.
- Status:
  - icode 0 -> HLT.
  - icode >B, or an invalid ifun as above -> INS; CC is not updated.
  - Otherwise AOK.
- Any accepted non-AOK instruction sets halted=1 at the accept edge. From then on in_ready=0 and the held result drains normally. Only reset clears halted.
- icode 1 (nop) passes through with valE=0 (the ALU adds 0+0) and stat=AOK.

Test Plan:
- Reset then OPq sub (icode 6, ifun 1), valB=5, valA=5 -> alu_control=01, alu_a=5, alu_b=5; next cycle valE=0, cc={1,0,0}, out_valid=1.
- OPq add with valB=0x7FFF_FFFF_FFFF_FFFF, valA=1 -> valE=0x8000_0000_0000_0000, cc={0,1,1}. A following jXX ifun 2 (l) gives cnd=0; jXX ifun 1 (le) gives cnd=0.
- pushq with valB=0x100 -> alu_a=0x100, alu_b=-8, valE=0xF8, CC unchanged.
- Back-pressure: hold out_ready=0 with two back-to-back valid instructions -> second stalls (in_ready=0) until out_ready=1. No loss and no duplication; accept and drain in the same cycle keeps out_valid=1.
- halt (icode 0) accepted -> stat=2, halted=1, in_ready=0 forever. Further in_valid is ignored; pulsing rst_n low restores in_ready=1 and cc={1,0,0}.
- icode 0xC, and OPq with ifun 5 -> stat=4, CC unchanged, halted=1. Asserting rst_n low while out_valid=1 -> out_valid=0 immediately (async).
